wb_console_master: RTL and testbench

- Bus initiator that turns a byte stream of characters into cell writes on the text-mode VGA device, which is the bus responder.
- Tracks a cursor over a COLS x ROWS grid and handles the control characters CR, LF, BS and FF.
- Scrolls the screen with read-then-write copies over the bus, then blanks the last row.
- Sits between a UART/CPU character source and the VGA device's bus port.

---
 rtl/wb_console_master_pkg.sv | 27 ++
 rtl/wb_console_master_if.sv | 12 +
 rtl/wb_master_port.sv | 87 ++++++++
 rtl/wb_console_master.sv | 197 +++++++++++++++++++
 tb/tb_wb_console_master.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_console_master_pkg.sv
// Shared types and constants for the text console bus master.
package wb_console_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPut,
    StScrlRd,
    StScrlWr,
    StClrRow,
    StClrAll
  } main_state_e;

  typedef enum logic [1:0] {
    BIdle,
    BLow,
    BHigh,
    BGap
  } bus_state_e;

  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_FF = 8'h0C;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  localparam logic [15:0] BLANK_CELL_DEFAULT = 16'h0720;

endpackage

// File: rtl/wb_console_master_if.sv
// Bus between the console master and the VGA text device; ack idles high.
interface wb_console_master_if;
  logic [31:0] addr;
  logic [31:0] dat2;
  logic [31:0] dat4;
  logic        sel;
  logic        we;
  logic        ack;

  modport master (output addr, dat2, sel, we, input dat4, ack);
  modport slave  (input addr, dat2, sel, we, output dat4, ack);
endinterface

// File: rtl/wb_master_port.sv
// One bus access per request: raise sel, wait ack low then high, drop sel for a gap cycle.
module wb_master_port
  import wb_console_master_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [31:0]                addr_i,
  input  logic [15:0]                wdata_i,
  output logic                       done_o,
  output logic [15:0]                rdata_o,
  wb_console_master_if.master        bus
);

  bus_state_e  state_q, state_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        unused_dat4_hi;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BIdle;
    else         state_q <= state_d;
  end

  // Bus outputs are registered so reset removes sel without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      BIdle: begin
        if (req_i) begin
          state_d = BLow;
          sel_d   = 1'b1;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      BLow:  if (!bus.ack) state_d = BHigh;
      BHigh: begin
        if (bus.ack) begin
          state_d = BGap;
          sel_d   = 1'b0;
          if (!we_q) rdata_d = bus.dat4[15:0];
        end
      end
      BGap:    state_d = BIdle;
      default: state_d = BIdle;
    endcase
  end

  always_comb begin
    done_o = (state_q == BHigh) && bus.ack;
  end

  assign rdata_o        = rdata_q;
  assign bus.sel        = sel_q;
  assign bus.we         = we_q;
  assign bus.addr       = addr_q;
  assign bus.dat2       = {16'h0000, wdata_q};
  assign unused_dat4_hi = ^bus.dat4[31:16];

endmodule

// File: rtl/wb_console_master.sv
// Character stream to text-cell writes: cursor tracking, control codes, bus-driven scroll/clear.
module wb_console_master
  import wb_console_master_pkg::*;
#(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [15:0] BLANK_CELL = BLANK_CELL_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [7:0]          io_in_char,
  input  logic [7:0]          io_in_color,
  wb_console_master_if.master io_bus,
  output logic [11:0]         io_cursor,
  output logic                io_busy
);

  localparam logic [11:0] ColsW        = 12'(COLS);
  localparam logic [11:0] ColLast      = 12'(COLS - 1);
  localparam logic [11:0] RowLast      = 12'(ROWS - 1);
  localparam logic [11:0] ScrlLast     = 12'((ROWS - 1) * COLS - 1);
  localparam logic [11:0] LastRowFirst = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] CellLast     = 12'(ROWS * COLS - 1);

  main_state_e state_q, state_d;
  logic [11:0] row_q, row_d, col_q, col_d, idx_q, idx_d;
  logic [7:0]  char_q, char_d, color_q, color_d;
  logic        rdy_q;
  logic        accept, done;
  logic [11:0] cursor, bus_cell;
  logic        bus_req, bus_we;
  logic [15:0] bus_wdata, rdata;
  logic [31:0] bus_addr;

  assign cursor      = row_q * ColsW + col_q;
  assign io_cursor   = cursor;
  // rdy_q keeps ready low while reset is held and rises on the first clock after release.
  assign io_in_ready = rdy_q && (state_q == StIdle);
  assign io_busy     = ~io_in_ready;
  assign accept      = io_in_valid && io_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      color_q <= '0;
    end else begin
      rdy_q   <= 1'b1;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    char_d  = char_q;
    color_d = color_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          char_d  = io_in_char;
          color_d = io_in_color;
          case (io_in_char)
            CHAR_CR: col_d = '0;
            CHAR_LF: begin
              if (row_q == RowLast) begin
                idx_d   = '0;
                state_d = StScrlRd;
              end else begin
                col_d = '0;
                row_d = row_q + 12'd1;
              end
            end
            CHAR_BS: if (col_q != '0) state_d = StPut;
            CHAR_FF: begin
              idx_d   = '0;
              state_d = StClrAll;
            end
            default: state_d = StPut;
          endcase
        end
      end
      StPut: begin
        if (done) begin
          state_d = StIdle;
          if (char_q == CHAR_BS) begin
            col_d = col_q - 12'd1;
          end else if (col_q != ColLast) begin
            col_d = col_q + 12'd1;
          end else if (row_q != RowLast) begin
            col_d = '0;
            row_d = row_q + 12'd1;
          end else begin
            idx_d   = '0;
            state_d = StScrlRd;
          end
        end
      end
      StScrlRd: if (done) state_d = StScrlWr;
      StScrlWr: begin
        if (done) begin
          if (idx_q == ScrlLast) begin
            idx_d   = LastRowFirst;
            state_d = StClrRow;
          end else begin
            idx_d   = idx_q + 12'd1;
            state_d = StScrlRd;
          end
        end
      end
      StClrRow: begin
        if (done) begin
          if (idx_q == CellLast) begin
            col_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 12'd1;
          end
        end
      end
      StClrAll: begin
        if (done) begin
          if (idx_q == CellLast) begin
            row_d   = '0;
            col_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 12'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request stays high for the whole state; the port only picks it up from BIdle.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b1;
    bus_cell  = idx_q;
    bus_wdata = BLANK_CELL;
    unique case (state_q)
      StPut: begin
        bus_req = 1'b1;
        if (char_q == CHAR_BS) begin
          bus_cell = cursor - 12'd1;
        end else begin
          bus_cell  = cursor;
          bus_wdata = {color_q, char_q};
        end
      end
      StScrlRd: begin
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_cell = idx_q + ColsW;
      end
      StScrlWr: begin
        bus_req   = 1'b1;
        bus_wdata = rdata;
      end
      StClrRow, StClrAll: bus_req = 1'b1;
      default: bus_req = 1'b0;
    endcase
  end

  assign bus_addr = BASE_ADDR + {20'd0, bus_cell};

  wb_master_port u_port (
    .clk_i   (clk),
    .rst_ni  (reset),
    .req_i   (bus_req),
    .we_i    (bus_we),
    .addr_i  (bus_addr),
    .wdata_i (bus_wdata),
    .done_o  (done),
    .rdata_o (rdata),
    .bus     (io_bus)
  );

endmodule

// File: tb/tb_wb_console_master.sv
// Directed bench: screen/cursor model plus responder memory, checked every cycle and at milestones.
module tb_wb_console_master;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [15:0] BLANK = 16'h0720;

  typedef struct {
    bit          we;
    int          addr;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = '0;
  logic [7:0]  in_color = '0;
  logic        in_ready, busy;
  logic [11:0] cursor;

  wb_console_master_if bus_if ();

  wb_console_master dut (
    .clk         (clk),
    .reset       (rst_n),
    .io_in_valid (in_valid),
    .io_in_ready (in_ready),
    .io_in_char  (in_char),
    .io_in_color (in_color),
    .io_bus      (bus_if),
    .io_cursor   (cursor),
    .io_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Responder: ack drops one cycle after sel, rises the next with the access performed.
  logic [15:0] resp_mem [0:4095];
  logic        served;
  int          acc_cnt = 0;
  logic [31:0] last_addr, last_dat;

  assign bus_if.dat4 = {16'h0000, resp_mem[bus_if.addr[11:0]]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_if.ack <= 1'b1;
      served     <= 1'b0;
    end else if (!bus_if.sel) begin
      served <= 1'b0;
    end else if (!served) begin
      if (bus_if.ack) begin
        bus_if.ack <= 1'b0;
      end else begin
        bus_if.ack <= 1'b1;
        served     <= 1'b1;
        acc_cnt    <= acc_cnt + 1;
        if (bus_if.we) begin
          resp_mem[bus_if.addr[11:0]] <= bus_if.dat2[15:0];
          last_addr <= bus_if.addr;
          last_dat  <= bus_if.dat2;
        end
      end
    end
  end

  // Screen model: expected access list, expected cell contents and cursor.
  acc_t        exp_q[$];
  int          exp_rd = 0;
  int          m_cur = 0;
  logic [15:0] m_mem [0:COLS*ROWS-1];

  task automatic model_put(input int a, input logic [15:0] d);
    acc_t e;
    e.we = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
    m_mem[a] = d;
  endtask

  task automatic model_scroll();
    acc_t e;
    for (int i = 0; i < (ROWS - 1) * COLS; i++) begin
      e.we = 1'b0; e.addr = i + COLS; e.data = '0;
      exp_q.push_back(e);
      model_put(i, m_mem[i + COLS]);
    end
    for (int i = (ROWS - 1) * COLS; i < ROWS * COLS; i++) model_put(i, BLANK);
  endtask

  task automatic model_char(input logic [7:0] c, input logic [7:0] colr);
    int row, cl;
    row = m_cur / COLS;
    cl  = m_cur % COLS;
    case (c)
      8'h0D: cl = 0;
      8'h0A: begin
        if (row == ROWS - 1) model_scroll();
        else row++;
        cl = 0;
      end
      8'h08: begin
        if (cl > 0) begin
          cl--;
          model_put(row * COLS + cl, BLANK);
        end
      end
      8'h0C: begin
        for (int i = 0; i < COLS * ROWS; i++) model_put(i, BLANK);
        row = 0;
        cl  = 0;
      end
      default: begin
        model_put(m_cur, {colr, c});
        if (cl == COLS - 1) begin
          cl = 0;
          if (row == ROWS - 1) model_scroll();
          else row++;
        end else begin
          cl++;
        end
      end
    endcase
    m_cur = row * COLS + cl;
  endtask

  // Per-cycle compare against the model.
  int run = 0;
  int last_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd = exp_q.size();
      run    = 0;
    end else begin
      chk("busy_vs_ready", {31'd0, busy}, {31'd0, !in_ready});
      if (in_ready) chk("cursor_idle", {20'd0, cursor}, m_cur);
      if (bus_if.sel) begin
        run++;
        if (exp_rd >= exp_q.size()) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_access: addr %0h we %0b, none expected", bus_if.addr, bus_if.we);
        end else begin
          chk("bus_we", {31'd0, bus_if.we}, {31'd0, exp_q[exp_rd].we});
          chk("bus_addr", bus_if.addr, BASE + 32'(exp_q[exp_rd].addr));
          if (exp_q[exp_rd].we) chk("bus_dat2", bus_if.dat2, {16'h0000, exp_q[exp_rd].data});
          if (served && bus_if.ack) exp_rd++;
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, in_ready}, 32'd1);
    chk("pending_accesses", exp_q.size() - exp_rd, 32'd0);
    #1;
  endtask

  task automatic drive(input logic [7:0] c, input logic [7:0] colr);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40000) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_char  = c;
    in_color = colr;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_char(c, colr);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] colr);
    drive(c, colr);
    wait_idle();
  endtask

  int base;
  int bad;

  initial begin
    // Reset values
    #12;
    chk("rst_sel", {31'd0, bus_if.sel}, 32'd0);
    chk("rst_we", {31'd0, bus_if.we}, 32'd0);
    chk("rst_addr", bus_if.addr, 32'd0);
    chk("rst_dat2", bus_if.dat2, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_cursor", {20'd0, cursor}, 32'd0);
    #15 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Single printable write
    base = acc_cnt;
    send(8'h41, 8'h1F);
    chk("t1_accesses", acc_cnt - base, 32'd1);
    chk("t1_addr", last_addr, 32'd0);
    chk("t1_dat2", last_dat, 32'h00001F41);
    chk("t1_sel_ge3", {31'd0, last_run >= 3}, 32'd1);
    chk("t1_cursor", {20'd0, cursor}, 32'd1);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);

    // Full row, then CR
    send(8'h0D, 8'h07);
    chk("cr_row0_cursor", {20'd0, cursor}, 32'd0);
    base = acc_cnt;
    for (int i = 0; i < COLS; i++) send(8'h41 + 8'(i % 26), 8'h02);
    chk("t2_accesses", acc_cnt - base, 32'd80);
    chk("t2_last_addr", last_addr, 32'd79);
    chk("t2_cursor", {20'd0, cursor}, 32'd80);
    base = acc_cnt;
    send(8'h0D, 8'h07);
    chk("t2_cr_no_bus", acc_cnt - base, 32'd0);
    chk("t2_cr_cursor", {20'd0, cursor}, 32'd80);

    // Backspace at column 0
    base = acc_cnt;
    send(8'h08, 8'h07);
    chk("bs0_no_bus", acc_cnt - base, 32'd0);
    chk("bs0_cursor", {20'd0, cursor}, 32'd80);

    // Form feed
    base = acc_cnt;
    send(8'h0C, 8'h07);
    chk("ff_accesses", acc_cnt - base, 32'd2400);
    chk("ff_last_addr", last_addr, 32'd2399);
    chk("ff_last_dat", last_dat, 32'h00000720);
    chk("ff_cursor", {20'd0, cursor}, 32'd0);

    // Backspace at cursor 5
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 8'h03);
    chk("bs_pre_cursor", {20'd0, cursor}, 32'd5);
    send(8'h08, 8'h07);
    chk("bs_addr", last_addr, 32'd4);
    chk("bs_dat", last_dat, 32'h00000720);
    chk("bs_cursor", {20'd0, cursor}, 32'd4);

    // Walk to the last cell, then scroll
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h07);
    chk("lf_cursor", {20'd0, cursor}, 32'd2320);
    for (int i = 0; i < COLS - 1; i++) send(8'h30 + 8'(i % 10), 8'h05);
    chk("pre_scroll_cursor", {20'd0, cursor}, 32'd2399);
    base = acc_cnt;
    send(8'h5A, 8'h07);
    chk("scroll_accesses", acc_cnt - base, 32'd4721);
    chk("scroll_cursor", {20'd0, cursor}, 32'd2320);
    chk("mem_2319", {16'd0, resp_mem[2319]}, 32'h075A);
    chk("mem_2399", {16'd0, resp_mem[2399]}, 32'h0720);
    chk("mem_2240", {16'd0, resp_mem[2240]}, 32'h0530);
    chk("mem_0", {16'd0, resp_mem[0]}, 32'h0720);
    bad = 0;
    for (int i = 0; i < COLS * ROWS; i++) if (resp_mem[i] !== m_mem[i]) bad++;
    chk("mem_all_cells", bad, 32'd0);

    // Reset in the middle of a scroll
    drive(8'h0A, 8'h07);
    repeat (100) @(negedge clk);
    begin
      int n;
      n = 0;
      while (!bus_if.sel && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pre_reset_sel", {31'd0, bus_if.sel}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("reset_drops_sel", {31'd0, bus_if.sel}, 32'd0);
    m_cur = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", {31'd0, in_ready}, 32'd1);
    chk("post_reset_cursor", {20'd0, cursor}, 32'd0);
    base = acc_cnt;
    send(8'h42, 8'h07);
    chk("post_reset_accesses", acc_cnt - base, 32'd1);
    chk("post_reset_addr", last_addr, 32'd0);
    chk("post_reset_dat", last_dat, 32'h00000742);
    chk("post_reset_cursor1", {20'd0, cursor}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
